pll_ctrl: RTL and testbench
===========================

Name: pll_ctrl

Overview:
Control-side counterpart of the on-chip PLL. It drives the PLL reference/feedback divider inputs and consumes the PLL lock indication. It accepts new divider configurations over a valid/ready handshake and sequences each change (bypass → program → wait lock → qualify lock → run). It drives the glitch-free clock-mux select and reports status, timeout and lock-loss events. It runs on the always-on reference-domain clock.

Parameters:
- REF_DIV_WIDTH, 4, width of the reference divider field.
- FB_DIV_WIDTH, 8, width of the feedback divider field.
- RST_REF_DIV, 1, reference divider driven after reset.
- RST_FB_DIV, 1, feedback divider driven after reset.
- GUARD_CYCLES, 4, cycles spent in bypass before the dividers change (≥1).
- LOCK_HOLD, 16, consecutive synchronized-locked cycles required to qualify lock (≥1).
- LOCK_TIMEOUT, 4096, maximum cycles from programming until lock qualifies (> LOCK_HOLD+BLANK_CYCLES).

Ports:
- clk_i  input  1  always-on reference-domain clock
- srst_i  input  1  synchronous, active-high reset
- cfg_valid_i  input  1  new configuration request
- cfg_ready_o  output  1  controller can accept a configuration
- cfg_ref_div_i  input  REF_DIV_WIDTH  requested reference divider
- cfg_fb_div_i  input  FB_DIV_WIDTH  requested feedback divider
- pll_ref_div_o  output  REF_DIV_WIDTH  registered reference divider to PLL
- pll_fb_div_o  output  FB_DIV_WIDTH  registered feedback divider to PLL
- pll_locked_i  input  1  PLL lock flag, asynchronous to clk_i
- clk_sel_o  output  1  1 = select PLL clock, 0 = bypass (reference) clock
- busy_o  output  1  relock sequence in progress
- locked_o  output  1  qualified lock; equals clk_sel_o
- timeout_o  output  1  sticky; set on lock timeout, cleared by an accepted configuration
- cfg_err_o  output  1  one-cycle pulse when an accepted configuration has a zero field
- lock_loss_cnt_o  output  8  saturating count of lock losses while in RUN

Behaviour:
- pll_locked_i passes through a 2-flop synchronizer; all logic uses the synchronized value (lk).
- Reset values:
  - State WAIT_LOCK, counters cleared.
  - pll_ref_div_o=RST_REF_DIV, pll_fb_div_o=RST_FB_DIV.
  - clk_sel_o=0, locked_o=0, busy_o=1, cfg_ready_o=0.
  - timeout_o=0, cfg_err_o=0, lock_loss_cnt_o=0.
- Reset dominates every other event, including mid-sequence; dividers return to their reset values.
- States:
  - SWITCH: clk_sel_o=0; count GUARD_CYCLES, then go to PROGRAM.
  - PROGRAM: one cycle; load the pending dividers into pll_*_div_o; clear tmo_cnt; go to WAIT_LOCK.
  - WAIT_LOCK: tmo_cnt increments every cycle. lk is ignored for the first BLANK_CYCLES (package constant, 4), because the PLL drops lock asynchronously after a divider change and the synchronizer adds latency. After that, lk=1 → HOLD with hold_cnt=1.
  - HOLD: tmo_cnt keeps incrementing. lk=1 → hold_cnt++. lk=0 → back to WAIT_LOCK (blanking not re-applied, tmo_cnt not cleared). hold_cnt==LOCK_HOLD → RUN.
  - RUN: clk_sel_o=1, locked_o=1, busy_o=0, cfg_ready_o=1. lk=0 → clk_sel_o=0 on the next cycle, lock_loss_cnt_o++ (saturates at 255), go to WAIT_LOCK with tmo_cnt cleared.
  - ERROR: entered when tmo_cnt reaches LOCK_TIMEOUT in WAIT_LOCK/HOLD. timeout_o=1, clk_sel_o=0, busy_o=0, cfg_ready_o=1. The dividers keep their current values; there is no automatic retry.
- Handshake:
  - cfg_ready_o is 1 only in RUN and ERROR. A transfer occurs when cfg_valid_i&cfg_ready_o.
  - Transfer with both fields nonzero: latch the pending fields, clear timeout_o, go to SWITCH; clk_sel_o=0 from the next cycle.
  - Transfer with either field zero: pulse cfg_err_o the next cycle; state and dividers are unchanged.
- Latency: from transfer to new dividers on the pins = GUARD_CYCLES+1 cycles.
- Simultaneous events:
  - Transfer and lk drop in the same RUN cycle: the configuration wins (go to SWITCH) and lock_loss_cnt_o still increments.
  - Lock qualification and timeout in the same cycle: lock wins (go to RUN).
- locked_o never asserts while clk_sel_o=0; clk_sel_o changes only in the states listed above.

Decomposition:
- Package pll_ctrl_pkg holds:
  - the state enum pll_ctrl_state_e (SWITCH, PROGRAM, WAIT_LOCK, HOLD, RUN, ERROR);
  - the constant BLANK_CYCLES=4;
  - the constant SYNC_STAGES=2.
- Sub-module: the 2-flop synchronizer, sync_2ff, reusable elsewhere.

Test Plan (parameters: GUARD_CYCLES=4, LOCK_HOLD=8, LOCK_TIMEOUT=64):
- Reset lock-up: release srst_i; PLL model asserts locked at cycle 20 → clk_sel_o=1 exactly 8 qualified cycles plus 2 synchronizer cycles later; dividers stay 1/1.
- Reconfigure: in RUN, send ref=2, fb=50 → clk_sel_o=0 next cycle; pll dividers = 2/50 exactly 5 cycles after the transfer; cfg_ready_o=0 until RUN is reached again.
- Timeout: hold pll_locked_i=0 → timeout_o=1 at tmo_cnt=64, clk_sel_o=0, cfg_ready_o=1. Then a valid configuration clears timeout_o and the sequence restarts.
- Lock loss: in RUN, drop pll_locked_i for 3 cycles → clk_sel_o=0 within 3 cycles, lock_loss_cnt_o=1, relock completes. Forcing 300 losses → count saturates at 255.
- Zero field: send fb=0 in RUN → one-cycle cfg_err_o, dividers and clk_sel_o unchanged.
- Lock chatter and reset mid-sequence: in HOLD, drop lk at hold_cnt=5 → WAIT_LOCK with the timeout counter preserved. Asserting srst_i during SWITCH → all outputs return to their reset values.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - shared types and constants for the PLL relock controller
//
// Purpose: state encoding, blanking/synchronizer constants and a saturating
// increment helper used by pll_ctrl.

package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    SWITCH,
    PROGRAM,
    WAIT_LOCK,
    HOLD,
    RUN,
    ERROR
  } pll_ctrl_state_e;

  // The PLL drops lock asynchronously after a divider change, and the
  // synchronizer delays that drop, so lock is ignored for this many cycles.
  localparam int BLANK_CYCLES = 4;
  localparam int SYNC_STAGES  = 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pll_ctrl_sync_2ff.sv
// rtl/pll_ctrl_sync_2ff.sv - multi-flop level synchronizer
//
// Purpose: brings an asynchronous level into the clk_i domain.
// Ports:
//   clk_i   destination clock
//   srst_i  synchronous active-high reset (clears the chain to 0)
//   d_i     asynchronous input level
//   q_o     synchronized level, STAGES cycles of latency

module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_ctrl.sv
// rtl/pll_ctrl.sv - PLL divider programming and lock qualification controller
//
// Purpose: accepts divider configurations, sequences bypass -> program ->
// wait lock -> qualify lock -> run, drives the clock-mux select and reports
// timeout and lock-loss events.
// Ports:
//   clk_i, srst_i                  reference-domain clock, sync active-high reset
//   cfg_valid_i/cfg_ready_o        configuration handshake
//   cfg_ref_div_i/cfg_fb_div_i     requested dividers
//   pll_ref_div_o/pll_fb_div_o     registered dividers to the PLL
//   pll_locked_i                   asynchronous PLL lock flag
//   clk_sel_o                      1 = PLL clock, 0 = reference clock
//   busy_o, locked_o               sequence in progress / qualified lock
//   timeout_o                      sticky lock timeout
//   cfg_err_o                      pulse: rejected configuration with a zero field
//   lock_loss_cnt_o                saturating lock-loss counter

module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int REF_DIV_WIDTH = 4,
  parameter int FB_DIV_WIDTH  = 8,
  parameter int RST_REF_DIV   = 1,
  parameter int RST_FB_DIV    = 1,
  parameter int GUARD_CYCLES  = 4,
  parameter int LOCK_HOLD     = 16,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [REF_DIV_WIDTH-1:0] cfg_ref_div_i,
  input  logic [FB_DIV_WIDTH-1:0]  cfg_fb_div_i,
  output logic [REF_DIV_WIDTH-1:0] pll_ref_div_o,
  output logic [FB_DIV_WIDTH-1:0]  pll_fb_div_o,
  input  logic                     pll_locked_i,
  output logic                     clk_sel_o,
  output logic                     busy_o,
  output logic                     locked_o,
  output logic                     timeout_o,
  output logic                     cfg_err_o,
  output logic [7:0]               lock_loss_cnt_o
);

  localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int HOLD_W = $clog2(LOCK_HOLD + 1);
  localparam int GRD_W  = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  localparam logic [TMO_W-1:0]  TMO_MAX    = TMO_W'(LOCK_TIMEOUT);
  localparam logic [TMO_W-1:0]  BLANK_LIM  = TMO_W'(BLANK_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(LOCK_HOLD);
  localparam logic [GRD_W-1:0]  GUARD_LAST = GRD_W'(GUARD_CYCLES - 1);

  pll_ctrl_state_e state_q, state_d;
  logic [GRD_W-1:0]         guard_q, guard_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d, tmo_inc;
  logic [HOLD_W-1:0]        hold_q, hold_d, hold_inc;
  logic [REF_DIV_WIDTH-1:0] pend_ref_q, pend_ref_d, ref_div_q, ref_div_d;
  logic [FB_DIV_WIDTH-1:0]  pend_fb_q, pend_fb_d, fb_div_q, fb_div_d;
  logic                     timeout_q, timeout_d, cfg_err_q, cfg_err_d;
  logic [7:0]               loss_q, loss_d;
  logic                     clk_sel_q, busy_q, ready_q, locked_q;
  logic                     lk, xfer, cfg_ok;

  sync_2ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .d_i    (pll_locked_i),
    .q_o    (lk)
  );

  assign tmo_inc  = tmo_q + TMO_W'(1);
  assign hold_inc = hold_q + HOLD_W'(1);
  assign xfer     = cfg_valid_i & ready_q;
  assign cfg_ok   = (|cfg_ref_div_i) & (|cfg_fb_div_i);

  always_comb begin
    state_d    = state_q;
    guard_d    = guard_q;
    tmo_d      = tmo_q;
    hold_d     = hold_q;
    pend_ref_d = pend_ref_q;
    pend_fb_d  = pend_fb_q;
    ref_div_d  = ref_div_q;
    fb_div_d   = fb_div_q;
    timeout_d  = timeout_q;
    cfg_err_d  = 1'b0;
    loss_d     = loss_q;

    unique case (state_q)
      SWITCH: begin
        if (guard_q == GUARD_LAST) state_d = PROGRAM;
        else                       guard_d = guard_q + GRD_W'(1);
      end
      PROGRAM: begin
        ref_div_d = pend_ref_q;
        fb_div_d  = pend_fb_q;
        tmo_d     = '0;
        hold_d    = '0;
        state_d   = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        tmo_d = tmo_inc;
        // Blanking is expressed through tmo_q: it restarts only where tmo_q
        // is cleared, so a HOLD dropout does not re-blank.
        if (lk && tmo_q >= BLANK_LIM && LOCK_HOLD == 1) begin
          state_d = RUN;
        end else if (tmo_inc == TMO_MAX) begin
          state_d   = ERROR;
          timeout_d = 1'b1;
        end else if (lk && tmo_q >= BLANK_LIM) begin
          hold_d  = HOLD_W'(1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        tmo_d = tmo_inc;
        // Qualification is tested before timeout so lock wins a tie.
        if (lk && hold_inc == HOLD_MAX) begin
          state_d = RUN;
        end else if (tmo_inc == TMO_MAX) begin
          state_d   = ERROR;
          timeout_d = 1'b1;
        end else if (lk) begin
          hold_d = hold_inc;
        end else begin
          state_d = WAIT_LOCK;
        end
      end
      RUN: begin
        if (!lk) begin
          loss_d  = sat_inc8(loss_q);
          tmo_d   = '0;
          state_d = WAIT_LOCK;
        end
      end
      ERROR: begin
      end
      default: state_d = WAIT_LOCK;
    endcase

    // ready_q is only set in RUN/ERROR, so this overrides those states only.
    if (xfer) begin
      if (cfg_ok) begin
        pend_ref_d = cfg_ref_div_i;
        pend_fb_d  = cfg_fb_div_i;
        timeout_d  = 1'b0;
        guard_d    = '0;
        state_d    = SWITCH;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= WAIT_LOCK;
      guard_q    <= '0;
      tmo_q      <= '0;
      hold_q     <= '0;
      pend_ref_q <= REF_DIV_WIDTH'(RST_REF_DIV);
      pend_fb_q  <= FB_DIV_WIDTH'(RST_FB_DIV);
      ref_div_q  <= REF_DIV_WIDTH'(RST_REF_DIV);
      fb_div_q   <= FB_DIV_WIDTH'(RST_FB_DIV);
      timeout_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      loss_q     <= '0;
      clk_sel_q  <= 1'b0;
      locked_q   <= 1'b0;
      busy_q     <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      guard_q    <= guard_d;
      tmo_q      <= tmo_d;
      hold_q     <= hold_d;
      pend_ref_q <= pend_ref_d;
      pend_fb_q  <= pend_fb_d;
      ref_div_q  <= ref_div_d;
      fb_div_q   <= fb_div_d;
      timeout_q  <= timeout_d;
      cfg_err_q  <= cfg_err_d;
      loss_q     <= loss_d;
      // Status outputs are decoded from the next state so they are flops.
      clk_sel_q  <= (state_d == RUN);
      locked_q   <= (state_d == RUN);
      busy_q     <= (state_d != RUN) && (state_d != ERROR);
      ready_q    <= (state_d == RUN) || (state_d == ERROR);
    end
  end

  assign cfg_ready_o     = ready_q;
  assign pll_ref_div_o   = ref_div_q;
  assign pll_fb_div_o    = fb_div_q;
  assign clk_sel_o       = clk_sel_q;
  assign locked_o        = locked_q;
  assign busy_o          = busy_q;
  assign timeout_o       = timeout_q;
  assign cfg_err_o       = cfg_err_q;
  assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_pll_ctrl.sv
// tb/tb_pll_ctrl.sv - self-checking bench for pll_ctrl

module tb_pll_ctrl;

  localparam int GUARD = 4;
  localparam int HOLDN = 8;
  localparam int TMO   = 64;
  localparam int BLANK = 4;
  localparam int SYNC  = 2;

  logic       clk = 1'b0;
  logic       srst, cfg_valid, cfg_ready, pll_locked;
  logic [3:0] cfg_ref_div, pll_ref_div;
  logic [7:0] cfg_fb_div, pll_fb_div, lock_loss_cnt;
  logic       clk_sel, busy, locked, timeout, cfg_err;

  always #5 clk = ~clk;

  pll_ctrl #(
    .REF_DIV_WIDTH(4), .FB_DIV_WIDTH(8), .RST_REF_DIV(1), .RST_FB_DIV(1),
    .GUARD_CYCLES(GUARD), .LOCK_HOLD(HOLDN), .LOCK_TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .srst_i(srst), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_ref_div_i(cfg_ref_div), .cfg_fb_div_i(cfg_fb_div),
    .pll_ref_div_o(pll_ref_div), .pll_fb_div_o(pll_fb_div),
    .pll_locked_i(pll_locked), .clk_sel_o(clk_sel), .busy_o(busy),
    .locked_o(locked), .timeout_o(timeout), .cfg_err_o(cfg_err),
    .lock_loss_cnt_o(lock_loss_cnt)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int exp_ref, exp_fb, exp_loss;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Edge at which clk_sel rises after a relock that starts at edge p
  // (dividers just programmed or RUN lost lock) with the PLL lock flag
  // high again right after edge p+r.
  function automatic int rise_edge(input int p, input int r);
    int a, b;
    a = p + BLANK + 1;
    b = p + r + SYNC + 1;
    return ((a > b) ? a : b) + HOLDN - 1;
  endfunction

  task automatic do_reset();
    srst = 1'b1; cfg_valid = 1'b0; pll_locked = 1'b0;
    cfg_ref_div = '0; cfg_fb_div = '0;
    tick(); tick();
    srst = 1'b0;
    cyc = 0;
    exp_ref = 1; exp_fb = 1; exp_loss = 0;
  endtask

  task automatic wait_rise(input int budget, output int edge_at);
    int n;
    n = 0; edge_at = -1;
    while (clk_sel !== 1'b1 && n < budget) begin tick(); n++; end
    if (clk_sel === 1'b1) edge_at = cyc;
  endtask

  task automatic test_reset();
    srst = 1'b1; cfg_valid = 1'b0; pll_locked = 1'b1;
    tick(); tick(); tick();
    tests_run++; if (clk_sel !== 1'b0) begin tests_failed++; $display("FAIL reset_clk_sel got %0b exp 0", clk_sel); end
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL reset_locked got %0b exp 0", locked); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL reset_busy got %0b exp 1", busy); end
    tests_run++; if (cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got %0b exp 0", cfg_ready); end
    tests_run++; if (timeout !== 1'b0 || cfg_err !== 1'b0) begin tests_failed++; $display("FAIL reset_flags got tmo=%0b err=%0b exp 0/0", timeout, cfg_err); end
    tests_run++; if (lock_loss_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_loss got %0d exp 0", lock_loss_cnt); end
    tests_run++; if (pll_ref_div !== 4'd1 || pll_fb_div !== 8'd1) begin tests_failed++; $display("FAIL reset_div got %0d/%0d exp 1/1", pll_ref_div, pll_fb_div); end
  endtask

  task automatic test_lockup();
    int d, e;
    d = $urandom_range(4, 40);
    do_reset();
    repeat (d) tick();
    pll_locked = 1'b1;
    wait_rise(80, e);
    tests_run++; if (e != d + SYNC + HOLDN) begin tests_failed++; $display("FAIL lockup_edge got %0d exp %0d", e, d + SYNC + HOLDN); end
    tests_run++; if (locked !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL lockup_status got lk=%0b busy=%0b rdy=%0b exp 1/0/1", locked, busy, cfg_ready); end
    tests_run++; if (pll_ref_div !== 4'(exp_ref) || pll_fb_div !== 8'(exp_fb)) begin tests_failed++; $display("FAIL lockup_div got %0d/%0d exp %0d/%0d", pll_ref_div, pll_fb_div, exp_ref, exp_fb); end
  endtask

  task automatic test_reconfig();
    for (int it = 0; it < 3; it++) begin
      int nref, nfb, r, t, p, e, n;
      bit early;
      nref = $urandom_range(2, 15); nfb = $urandom_range(2, 255); r = $urandom_range(0, 6);
      cfg_ref_div = 4'(nref); cfg_fb_div = 8'(nfb); cfg_valid = 1'b1;
      tick(); t = cyc;
      cfg_valid = 1'b0;
      tests_run++; if (clk_sel !== 1'b0 || cfg_ready !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL reconfig_bypass got sel=%0b rdy=%0b busy=%0b exp 0/0/1", clk_sel, cfg_ready, busy); end
      repeat (GUARD) tick();
      tests_run++; if (pll_ref_div !== 4'(exp_ref) || pll_fb_div !== 8'(exp_fb)) begin tests_failed++; $display("FAIL reconfig_old_div at T+%0d got %0d/%0d exp %0d/%0d", cyc - t, pll_ref_div, pll_fb_div, exp_ref, exp_fb); end
      tick(); p = cyc;
      exp_ref = nref; exp_fb = nfb;
      tests_run++; if (pll_ref_div !== 4'(exp_ref) || pll_fb_div !== 8'(exp_fb)) begin tests_failed++; $display("FAIL reconfig_new_div at T+%0d got %0d/%0d exp %0d/%0d", p - t, pll_ref_div, pll_fb_div, exp_ref, exp_fb); end
      if (r > 0) pll_locked = 1'b0;
      early = 1'b0; e = -1; n = 0;
      while (clk_sel !== 1'b1 && n < 100) begin
        tick(); n++;
        if (cyc == p + r) pll_locked = 1'b1;
        if (clk_sel === 1'b1) e = cyc;
        else if (cfg_ready === 1'b1) early = 1'b1;
      end
      pll_locked = 1'b1;
      tests_run++; if (e != rise_edge(p, r)) begin tests_failed++; $display("FAIL reconfig_relock r=%0d got %0d exp %0d", r, e, rise_edge(p, r)); end
      tests_run++; if (early !== 1'b0 || cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL reconfig_ready early=%0b rdy=%0b exp 0/1", early, cfg_ready); end
    end
  endtask

  task automatic test_zero_field();
    for (int it = 0; it < 3; it++) begin
      int sel;
      sel = $urandom_range(0, 2);
      cfg_ref_div = (sel == 1) ? 4'd0 : 4'($urandom_range(1, 15));
      cfg_fb_div  = (sel == 0) ? 8'd0 : ((sel == 2) ? 8'd0 : 8'($urandom_range(1, 255)));
      if (sel == 2) cfg_ref_div = 4'd0;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      tests_run++; if (cfg_err !== 1'b1) begin tests_failed++; $display("FAIL zero_err_pulse got %0b exp 1", cfg_err); end
      tests_run++; if (clk_sel !== 1'b1 || cfg_ready !== 1'b1 || pll_ref_div !== 4'(exp_ref) || pll_fb_div !== 8'(exp_fb)) begin tests_failed++; $display("FAIL zero_unchanged got sel=%0b rdy=%0b div=%0d/%0d exp 1/1 %0d/%0d", clk_sel, cfg_ready, pll_ref_div, pll_fb_div, exp_ref, exp_fb); end
      tick();
      tests_run++; if (cfg_err !== 1'b0 || clk_sel !== 1'b1) begin tests_failed++; $display("FAIL zero_err_clear got err=%0b sel=%0b exp 0/1", cfg_err, clk_sel); end
    end
  endtask

  task automatic test_lock_loss();
    for (int it = 0; it < 3; it++) begin
      int m, d0, fall, rise, n;
      m = (it == 0) ? 3 : $urandom_range(1, 8);
      d0 = cyc; fall = -1; rise = -1; n = 0;
      pll_locked = 1'b0;
      while (rise < 0 && n < 60) begin
        tick(); n++;
        if (cyc == d0 + m) pll_locked = 1'b1;
        if (fall < 0 && clk_sel === 1'b0) fall = cyc;
        else if (fall >= 0 && clk_sel === 1'b1) rise = cyc;
      end
      pll_locked = 1'b1;
      exp_loss = (exp_loss == 255) ? 255 : exp_loss + 1;
      tests_run++; if (fall != d0 + SYNC + 1) begin tests_failed++; $display("FAIL loss_fall m=%0d got %0d exp %0d", m, fall, d0 + SYNC + 1); end
      tests_run++; if (rise != rise_edge(d0 + SYNC + 1, m - SYNC - 1)) begin tests_failed++; $display("FAIL loss_relock m=%0d got %0d exp %0d", m, rise, rise_edge(d0 + SYNC + 1, m - SYNC - 1)); end
      tests_run++; if (lock_loss_cnt !== 8'(exp_loss)) begin tests_failed++; $display("FAIL loss_count got %0d exp %0d", lock_loss_cnt, exp_loss); end
    end
  endtask

  task automatic test_saturate();
    int bad;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      int n;
      pll_locked = 1'b0; tick(); pll_locked = 1'b1;
      n = 0;
      while (clk_sel === 1'b1 && n < 10) begin tick(); n++; end
      while (clk_sel !== 1'b1 && n < 60) begin tick(); n++; end
      if (clk_sel !== 1'b1) bad++;
      exp_loss = (exp_loss == 255) ? 255 : exp_loss + 1;
      if (i == 99) begin
        tests_run++; if (lock_loss_cnt !== 8'(exp_loss)) begin tests_failed++; $display("FAIL sat_mid got %0d exp %0d", lock_loss_cnt, exp_loss); end
      end
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL sat_relock got %0d stuck iterations exp 0", bad); end
    tests_run++; if (lock_loss_cnt !== 8'(exp_loss) || exp_loss != 255) begin tests_failed++; $display("FAIL sat_final got %0d exp 255", lock_loss_cnt); end
  endtask

  task automatic test_reset_mid();
    cfg_ref_div = 4'($urandom_range(1, 15)); cfg_fb_div = 8'($urandom_range(1, 255)); cfg_valid = 1'b1;
    tick(); cfg_valid = 1'b0;
    tick(); tick();
    tests_run++; if (clk_sel !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL mid_in_switch got sel=%0b busy=%0b exp 0/1", clk_sel, busy); end
    srst = 1'b1;
    tick();
    tests_run++; if (pll_ref_div !== 4'd1 || pll_fb_div !== 8'd1) begin tests_failed++; $display("FAIL mid_reset_div got %0d/%0d exp 1/1", pll_ref_div, pll_fb_div); end
    tests_run++; if (clk_sel !== 1'b0 || locked !== 1'b0 || busy !== 1'b1 || cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_status got sel=%0b lk=%0b busy=%0b rdy=%0b exp 0/0/1/0", clk_sel, locked, busy, cfg_ready); end
    tests_run++; if (timeout !== 1'b0 || cfg_err !== 1'b0 || lock_loss_cnt !== 8'd0) begin tests_failed++; $display("FAIL mid_reset_flags got tmo=%0b err=%0b loss=%0d exp 0/0/0", timeout, cfg_err, lock_loss_cnt); end
    srst = 1'b0;
  endtask

  task automatic test_timeout();
    int nref, nfb, t, p, e;
    do_reset();
    repeat (TMO - 1) tick();
    tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL tmo_early at %0d got 1 exp 0", cyc); end
    tick();
    tests_run++; if (timeout !== 1'b1 || clk_sel !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL tmo_error got tmo=%0b sel=%0b rdy=%0b busy=%0b exp 1/0/1/0", timeout, clk_sel, cfg_ready, busy); end
    repeat ($urandom_range(1, 10)) tick();
    tests_run++; if (timeout !== 1'b1 || pll_ref_div !== 4'd1 || pll_fb_div !== 8'd1) begin tests_failed++; $display("FAIL tmo_sticky got tmo=%0b div=%0d/%0d exp 1 1/1", timeout, pll_ref_div, pll_fb_div); end
    nref = $urandom_range(1, 15); nfb = $urandom_range(1, 255);
    cfg_ref_div = 4'(nref); cfg_fb_div = 8'(nfb); cfg_valid = 1'b1;
    tick(); t = cyc; cfg_valid = 1'b0;
    tests_run++; if (timeout !== 1'b0 || busy !== 1'b1 || cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL tmo_clear got tmo=%0b busy=%0b rdy=%0b exp 0/1/0", timeout, busy, cfg_ready); end
    repeat (GUARD + 1) tick(); p = cyc;
    tests_run++; if (pll_ref_div !== 4'(nref) || pll_fb_div !== 8'(nfb)) begin tests_failed++; $display("FAIL tmo_new_div at T+%0d got %0d/%0d exp %0d/%0d", p - t, pll_ref_div, pll_fb_div, nref, nfb); end
    pll_locked = 1'b1;
    wait_rise(60, e);
    tests_run++; if (e != rise_edge(p, 0)) begin tests_failed++; $display("FAIL tmo_relock got %0d exp %0d", e, rise_edge(p, 0)); end
  endtask

  task automatic test_boundary();
    for (int d = TMO - SYNC - HOLDN; d <= TMO - SYNC - HOLDN + 1; d++) begin
      bit lock_wins;
      lock_wins = (d + SYNC + HOLDN <= TMO);
      do_reset();
      repeat (d) tick();
      pll_locked = 1'b1;
      repeat (TMO - d) tick();
      tests_run++; if (clk_sel !== lock_wins || timeout !== !lock_wins) begin tests_failed++; $display("FAIL tie_d%0d got sel=%0b tmo=%0b exp %0b/%0b", d, clk_sel, timeout, lock_wins, !lock_wins); end
    end
  endtask

  task automatic test_chatter();
    int d, e;
    bit rose;
    // Lock drops after 5 qualified cycles and stays low: the timeout must
    // still land at its original edge.
    d = $urandom_range(4, 20);
    do_reset();
    repeat (d) tick();
    pll_locked = 1'b1;
    repeat (5) tick();
    pll_locked = 1'b0;
    rose = 1'b0;
    while (cyc < TMO - 1) begin tick(); if (clk_sel === 1'b1) rose = 1'b1; end
    tests_run++; if (rose !== 1'b0 || timeout !== 1'b0) begin tests_failed++; $display("FAIL chatter_pre got rose=%0b tmo=%0b exp 0/0", rose, timeout); end
    tick();
    tests_run++; if (timeout !== 1'b1) begin tests_failed++; $display("FAIL chatter_tmo_kept got %0b exp 1 at %0d", timeout, cyc); end
    // Short dropout then recovery: qualification restarts from one without blanking.
    d = $urandom_range(4, 20);
    do_reset();
    repeat (d) tick();
    pll_locked = 1'b1;
    repeat (5) tick();
    pll_locked = 1'b0;
    repeat (2) tick();
    pll_locked = 1'b1;
    wait_rise(60, e);
    tests_run++; if (e != d + 7 + SYNC + HOLDN) begin tests_failed++; $display("FAIL chatter_requalify got %0d exp %0d", e, d + 7 + SYNC + HOLDN); end
  endtask

  initial begin
    srst = 1'b1; cfg_valid = 1'b0; pll_locked = 1'b0;
    cfg_ref_div = '0; cfg_fb_div = '0;
    test_reset();
    test_lockup();
    test_reconfig();
    test_zero_field();
    test_lock_loss();
    test_saturate();
    test_reset_mid();
    test_timeout();
    test_boundary();
    test_chatter();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
